cdr_phase_controller: RTL
=========================

Name: cdr_phase_controller

Overview:
- Digital loop filter that generates the phase_shift code driving phase_interpolator.
- Upstream neighbour of the phase interpolator; replaces the fixed open-loop ramp with closed-loop control.
- Consumes early/late votes from a bang-bang phase detector, majority-votes them over a window, and runs a proportional plus integral (frequency) path.
- Output is a wrapping PHASE_W-bit phase code.

Parameters:
- PHASE_W, 9, phase code width; code wraps modulo 2^PHASE_W.
- FREQ_W, 12, signed frequency integrator width.
- VOTE_LEN, 16, number of pd_valid samples per vote window (power of 2, at least 2).
- KP_ACQ, 8, proportional step in ACQUIRE.
- KP_TRK, 2, proportional step in TRACK.
- KI_SHIFT, 4, arithmetic right shift applied to the integrator before adding it to the phase.
- LOCK_CNT, 8, consecutive-decision count used for lock and unlock.

Ports:
- clk, input, 1, sampling clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, loop run; when low, all state holds.
- pd_valid, input, 1, early/late sample qualifier.
- early, input, 1, recovered clock early; the phase code must decrease.
- late, input, 1, recovered clock late; the phase code must increase.
- phase_shift, output, PHASE_W, registered phase code to phase_interpolator.
- freq_word, output, FREQ_W, signed integrator value, for debug.
- decision_valid, output, 1, one-cycle pulse when a window decision is applied.
- locked, output, 1, high in TRACK state.

Behaviour:
- Reset (asynchronous, rst_n=0): phase_shift=0, freq_word=0, decision_valid=0, locked=0, state=ACQUIRE, vote sum=0, sample count=0, prev_dec=none, run counters=0. Reset asserted mid-window discards the partial window.
- Sample value on each cycle with enable=1 and pd_valid=1:
  - late and not early gives +1.
  - early and not late gives -1.
  - both or neither gives 0.
  - Every valid sample counts toward the window, including 0-valued ones.
- Vote sum: signed, width clog2(VOTE_LEN)+2 bits.
- Window close: on the VOTE_LEN-th valid sample, compute total = sum + current sample.
  - d = sign(total).
  - Clear the sum and count in the same edge.
- If d=0: no update and decision_valid stays 0.
- If d is nonzero, on the next edge (latency 1 clk from the closing sample):
  - freq_int = sat(freq_int + d), saturating to ±(2^(FREQ_W-1)-1).
  - step = d*KP + (new freq_int >>> KI_SHIFT), where KP follows the current state.
  - phase_shift = (phase_shift + step) mod 2^PHASE_W; this wraps in both directions, never saturates.
  - decision_valid pulses high for 1 cycle.
- FSM states: ACQUIRE and TRACK. Counters update only on nonzero decisions.
  - alt_cnt: increments when d differs from prev_dec, else clears to 0.
  - same_cnt: increments when d equals prev_dec, else clears to 1.
- ACQUIRE to TRACK: when alt_cnt reaches LOCK_CNT.
  - Clear both counters.
  - locked=1 on the same edge as the phase update.
  - The phase update on that edge uses KP_ACQ.
- TRACK to ACQUIRE: when same_cnt reaches LOCK_CNT.
  - locked=0.
  - Clear both counters.
- enable=0:
  - Samples are ignored.
  - Window count, sum, integrator, phase and FSM all hold.
  - A decision already computed still applies on the next edge.
- pd_valid arriving on the decision-apply edge is accumulated into the new window (no lost samples).

Decomposition:
- Package serdes_cdr_pkg holds:
  - cdr_state_e enum {ACQUIRE, TRACK}.
  - Default PHASE_W/FREQ_W localparams.
  - The sat_add function for the integrator.
- Sub-module bb_vote_window (VOTE_LEN):
  - Inputs: clk, rst_n, enable, pd_valid, early, late.
  - Outputs: dec_valid, dec (2-bit signed).
  - The top level contains the integrator, phase accumulator and FSM.

Test Plan:
- Reset then 16 valid late-only samples gives phase_shift 0→8, freq_word=1, decision_valid pulse 1 clk after the 16th sample, locked=0.
- 256 windows of late-only:
  - Window 16: step becomes 8+1=9.
  - Phase wraps past 511: verify a pre-wrap value of 504 plus step 9 gives 1.
  - freq_word climbs monotonically.
- Force freq_word near +2047 with continuous late: it saturates at 2047 and never wraps negative; phase still advances by 8+127.
- Alternating late/early windows:
  - After 9 decisions (8 sign changes), locked=1.
  - Subsequent steps use KP_TRK=2.
  - Then 8 same-sign windows return locked=0.
- Window of 8 early and 8 late samples (sum 0): no decision_valid; phase and freq unchanged; the next window starts cleanly.
- Toggle enable=0 mid-window for 20 clocks with pd_valid active: no state change. Deassert rst_n mid-window: all outputs go to 0 immediately and asynchronously.

Source files
------------

// File: rtl/serdes_cdr_pkg.sv
// Shared types and helpers for the CDR phase loop: FSM state, default widths,
// and the saturating add used by the frequency integrator.
package serdes_cdr_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } cdr_state_e;

    localparam int PHASE_W_DEF = 9;
    localparam int FREQ_W_DEF  = 12;

    // Symmetric clamp to +/-(2^(width-1)-1) so the integrator never wraps sign.
    function automatic int sat_add(input int acc, input int inc, input int width);
        int lim;
        int sum;
        lim = (1 << (width - 1)) - 1;
        sum = acc + inc;
        if (sum > lim)  return lim;
        if (sum < -lim) return -lim;
        return sum;
    endfunction

endpackage

// File: rtl/bb_vote_window.sv
// Majority vote of bang-bang early/late samples over VOTE_LEN valid samples;
// emits a registered sign decision, suppressed when the window sums to zero.
module bb_vote_window
    import serdes_cdr_pkg::*;
#(
    parameter int VOTE_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pd_valid,
    input  logic              early,
    input  logic              late,
    output logic              dec_valid,
    output logic signed [1:0] dec
);
    localparam int CNT_W = $clog2(VOTE_LEN);
    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0]        cnt_q;
    logic signed [SUM_W-1:0] sum_q, sum_d, sample;
    logic                    dec_valid_q;
    logic signed [1:0]       dec_q;

    always_comb begin
        sample = '0;
        if (late && !early)
            sample = SUM_W'(1);
        else if (early && !late)
            sample = '1;
        sum_d = sum_q + sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            sum_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_q       <= 2'sb00;
        end else begin
            dec_valid_q <= 1'b0;
            if (enable && pd_valid) begin
                if (cnt_q == CNT_W'(VOTE_LEN - 1)) begin
                    cnt_q       <= '0;
                    sum_q       <= '0;
                    dec_valid_q <= (sum_d != '0);
                    dec_q       <= sum_d[SUM_W-1] ? 2'sb11 : 2'sb01;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    sum_q <= sum_d;
                end
            end
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec       = dec_q;

endmodule

// File: rtl/cdr_phase_controller.sv
// Closed-loop CDR filter: proportional + integral path on windowed bang-bang
// votes, producing a wrapping phase code for the phase interpolator.
module cdr_phase_controller
    import serdes_cdr_pkg::*;
#(
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int VOTE_LEN = 16,
    parameter int KP_ACQ   = 8,
    parameter int KP_TRK   = 2,
    parameter int KI_SHIFT = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     pd_valid,
    input  logic                     early,
    input  logic                     late,
    output logic [PHASE_W-1:0]       phase_shift,
    output logic signed [FREQ_W-1:0] freq_word,
    output logic                     decision_valid,
    output logic                     locked
);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic                     win_valid;
    logic signed [1:0]        win_dec;

    cdr_state_e               state_q;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic signed [FREQ_W-1:0] freq_q, freq_d;
    logic signed [1:0]        prev_q;
    logic [CNT_W-1:0]         alt_q, alt_d, same_q, same_d;
    logic                     dv_q, locked_q;
    logic                     have_prev;
    int                       step;

    bb_vote_window #(.VOTE_LEN(VOTE_LEN)) u_vote (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pd_valid  (pd_valid),
        .early     (early),
        .late      (late),
        .dec_valid (win_valid),
        .dec       (win_dec)
    );

    // prev_q == 0 means no decision seen yet; the first decision neither
    // counts as a sign change nor as a repeat.
    always_comb begin
        have_prev = (prev_q != 2'sb00);
        freq_d    = FREQ_W'(sat_add(int'(freq_q), int'(win_dec), FREQ_W));
        step      = ((state_q == TRACK) ? KP_TRK : KP_ACQ) * int'(win_dec)
                    + int'(freq_d >>> KI_SHIFT);
        phase_d   = PHASE_W'(int'(phase_q) + step);

        if (have_prev && win_dec != prev_q)
            alt_d = (alt_q == CNT_W'(LOCK_CNT)) ? alt_q : alt_q + 1'b1;
        else
            alt_d = '0;

        if (have_prev && win_dec == prev_q)
            same_d = (same_q == CNT_W'(LOCK_CNT)) ? same_q : same_q + 1'b1;
        else
            same_d = CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACQUIRE;
            phase_q  <= '0;
            freq_q   <= '0;
            prev_q   <= 2'sb00;
            alt_q    <= '0;
            same_q   <= '0;
            dv_q     <= 1'b0;
            locked_q <= 1'b0;
        end else if (win_valid) begin
            phase_q <= phase_d;
            freq_q  <= freq_d;
            prev_q  <= win_dec;
            alt_q   <= alt_d;
            same_q  <= same_d;
            dv_q    <= 1'b1;
            case (state_q)
                ACQUIRE: if (alt_d == CNT_W'(LOCK_CNT)) begin
                    state_q  <= TRACK;
                    locked_q <= 1'b1;
                    alt_q    <= '0;
                    same_q   <= '0;
                end
                TRACK: if (same_d == CNT_W'(LOCK_CNT)) begin
                    state_q  <= ACQUIRE;
                    locked_q <= 1'b0;
                    alt_q    <= '0;
                    same_q   <= '0;
                end
                default: state_q <= ACQUIRE;
            endcase
        end else begin
            dv_q <= 1'b0;
        end
    end

    assign phase_shift    = phase_q;
    assign freq_word      = freq_q;
    assign decision_valid = dv_q;
    assign locked         = locked_q;

endmodule
